// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and command master FSM state type.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } mst_state_e;

  // A command may go on the bus only with a supported size and a naturally aligned address.
  function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~addr_lo[0];
      HSIZE_WORD: ok = (addr_lo == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_wait_timer.sv
// Saturating count of consecutive HREADY-low cycles with an expiry flag.
// Only built when AHB_MASTER_TIMEOUT_EN is defined, since the master
// instantiates it only in that configuration.
`ifdef AHB_MASTER_TIMEOUT_EN
module ahb_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic cnt_en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // Expiry fires on the cycle whose closing edge would be the LIMIT-th low cycle.
  assign expired = cnt_en && (cnt == CW'(LIMIT - 1));

  // Count while enabled, saturate at the expiry point, clear whenever disabled.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt <= '0;
    end else if (!cnt_en) begin
      cnt <= '0;
    end else if (cnt != CW'(LIMIT - 1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/ahb_lite_cmd_master.sv
// Valid/ready command to single AHB-Lite NONSEQ transfer master.
// Optional feature macro: AHB_MASTER_TIMEOUT_EN (abort after TIMEOUT_CYCLES
// consecutive HREADY-low cycles and flag the response as a timeout).
module ahb_lite_cmd_master
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              HSEL,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [1:0]        HTRANS,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  if (DATA_W != 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ahb_lite_cmd_master: DATA_W must be 32 and TIMEOUT_CYCLES >= 1");
  end

  mst_state_e        state;
  logic [DATA_W-1:0] wdata_q;
  logic              cmd_ok;
  logic              tmo_expired;

  assign cmd_ok    = cmd_legal(cmd_size, cmd_addr[1:0]);
  assign cmd_ready = HRESETn && (state == ST_IDLE);

`ifdef AHB_MASTER_TIMEOUT_EN
  logic wait_cnt_en;
  logic rsp_load;

  assign wait_cnt_en = ((state == ST_ADDR) || (state == ST_DATA)) && !HREADY;

  ahb_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait_timer (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .cnt_en  (wait_cnt_en),
    .expired (tmo_expired)
  );

  // Every edge that launches a response: illegal command, bus completion or abort.
  assign rsp_load = ((state == ST_IDLE) && cmd_valid && !cmd_ok) ||
                    ((state == ST_DATA) && HREADY) || tmo_expired;

  // Timeout flag is refreshed with each response and held in between, like rsp_err.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_timeout <= 1'b0;
    end else if (rsp_load) begin
      rsp_timeout <= tmo_expired;
    end
  end
`else
  assign tmo_expired = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // Command FSM: accept, address phase, data phase, one-cycle response.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      HSEL      <= 1'b0;
      HTRANS    <= HTRANS_IDLE;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HSIZE     <= 3'd0;
      HWDATA    <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_ok) begin
              state   <= ST_ADDR;
              HSEL    <= 1'b1;
              HTRANS  <= HTRANS_NONSEQ;
              HADDR   <= cmd_addr;
              HWRITE  <= cmd_write;
              HSIZE   <= cmd_size;
              wdata_q <= cmd_wdata;
            end else begin
              // Rejected locally: answer with an error and never touch the bus.
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            state  <= ST_DATA;
            HSEL   <= 1'b0;
            HTRANS <= HTRANS_IDLE;
            HWDATA <= wdata_q;
          end else if (tmo_expired) begin
            state     <= ST_RESP;
            HSEL      <= 1'b0;
            HTRANS    <= HTRANS_IDLE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        ST_DATA: begin
          // An HRESP=1 cycle with HREADY low is just another wait state.
          if (HREADY) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= HRESP;
            rsp_rdata <= (HWRITE || HRESP) ? '0 : HRDATA;
          end else if (tmo_expired) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Directed bench for ahb_lite_cmd_master with a small AHB-Lite memory slave
// model and a response scoreboard (expected data, error, timeout, arrival cycle).
`timescale 1ns/1ps
module tb_ahb_lite_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        HSEL, HWRITE, HREADY, HRESP;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        tmo;
    int          ecyc;
  } exp_t;
  exp_t sb[$];

  // Slave model controls
  int          cfg_waits = 0;
  logic        cfg_err   = 1'b0;
  logic        force_low = 1'b0;
  logic        dp_active, dp_write, dp_err;
  logic [31:0] dp_addr;
  int          waits_left;
  logic [31:0] mem [0:15];

  ahb_lite_cmd_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) cyc <= cyc + 1;

  assign HREADY = !force_low && !(dp_active && waits_left != 0);
  assign HRESP  = dp_active && dp_err;
  assign HRDATA = (dp_active && !dp_write) ? mem[dp_addr[5:2]] : 32'h0;

  // Memory slave: captures address phases, inserts configured waits / two-cycle error.
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_active  <= 1'b0;
      dp_write   <= 1'b0;
      dp_err     <= 1'b0;
      dp_addr    <= 32'h0;
      waits_left <= 0;
    end else begin
      if (dp_active && HREADY) begin
        if (dp_write && !dp_err) mem[dp_addr[5:2]] <= HWDATA;
        dp_active <= 1'b0;
      end else if (dp_active) begin
        waits_left <= waits_left - 1;
      end
      if (HSEL && HTRANS == 2'b10 && HREADY) begin
        dp_active  <= 1'b1;
        dp_addr    <= HADDR;
        dp_write   <= HWRITE;
        dp_err     <= cfg_err;
        waits_left <= cfg_err ? 1 : cfg_waits;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every rsp_valid cycle must match the oldest expectation.
  always @(negedge HCLK) begin
    if (HRESETn && rsp_valid) begin
      exp_t e;
      chk("rsp_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rd);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_timeout", rsp_timeout, e.tmo);
        chk("rsp_cycle", cyc, e.ecyc);
      end
    end
  end

  // Present one command; returns at the negedge right after the accepting edge.
  task automatic send(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wd, input logic exp_rsp, input logic [31:0] erd,
                      input logic eerr, input logic etmo, input int lat);
    int guard = 0;
    @(negedge HCLK);
    while (!cmd_ready && guard < 200) begin
      @(negedge HCLK);
      guard++;
    end
    chk("cmd_ready_before_send", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_wdata = wd;
    if (exp_rsp) sb.push_back('{erd, eerr, etmo, cyc + 1 + lat});
    @(negedge HCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int guard = 0;
    while ((sb.size() != 0 || !cmd_ready) && guard < limit) begin
      @(negedge HCLK);
      guard++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    HRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_size  = 3'd0;
    cmd_wdata = 32'h0;
    repeat (3) @(negedge HCLK);
    chk("rst_bus", {HSEL, HTRANS, HWRITE, HSIZE, HADDR}, 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk("idle_cmd_ready", cmd_ready, 1);

    // Zero-wait write: NONSEQ for one cycle, write data in the following cycle
    send(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 1'b0, 2);
    chk("wr_addr_phase", {HSEL, HTRANS, HWRITE, HADDR}, {1'b1, 2'b10, 1'b1, 32'h10});
    @(negedge HCLK);
    chk("wr_data_phase_ctrl", {HSEL, HTRANS}, 0);
    chk("wr_data_phase_hwdata", HWDATA, 32'hDEADBEEF);
    drain(50);

    // Read back
    send(1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 2);
    drain(50);

    // Write with two data-phase waits: HWDATA held
    cfg_waits = 2;
    send(1'b1, 32'h20, 3'd2, 32'h5A5A1234, 1'b1, 32'h0, 1'b0, 1'b0, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      chk("wait_wr_hwdata", HWDATA, 32'h5A5A1234);
    end
    drain(50);

    // Read with three data-phase waits: address held, response 3 cycles late
    cfg_waits = 3;
    send(1'b0, 32'h20, 3'd2, 32'h0, 1'b1, 32'h5A5A1234, 1'b0, 1'b0, 5);
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      chk("wait_rd_haddr", {HTRANS, HADDR}, {2'b00, 32'h20});
    end
    drain(50);
    cfg_waits = 0;

    // Two-cycle ERROR responses: write and read both report err with zero data
    cfg_err = 1'b1;
    send(1'b1, 32'h40, 3'd2, 32'h11112222, 1'b1, 32'h0, 1'b1, 1'b0, 3);
    drain(50);
    send(1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 3);
    drain(50);
    cfg_err = 1'b0;
    send(1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 2);
    drain(50);

    // Locally rejected commands: no bus activity, immediate error response
    send(1'b1, 32'h12, 3'd2, 32'hCAFEF00D, 1'b1, 32'h0, 1'b1, 1'b0, 0);
    chk("misalign_no_bus", {HSEL, HTRANS}, 0);
    drain(50);
    send(1'b0, 32'h10, 3'd3, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 0);
    chk("size3_no_bus", {HSEL, HTRANS}, 0);
    drain(50);
    send(1'b0, 32'h21, 3'd1, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 0);
    drain(50);
    send(1'b0, 32'h22, 3'd1, 32'h0, 1'b1, 32'h5A5A1234, 1'b0, 1'b0, 2);
    drain(50);
    send(1'b0, 32'h23, 3'd0, 32'h0, 1'b1, 32'h5A5A1234, 1'b0, 1'b0, 2);
    drain(50);
    repeat (2) @(negedge HCLK);
    chk("rsp_hold", {rsp_valid, rsp_err, rsp_rdata}, {1'b0, 1'b0, 32'h5A5A1234});

    // Reset during the address phase: bus drops at once, no response
    send(1'b1, 32'h30, 3'd2, 32'h77778888, 1'b0, 32'h0, 1'b0, 1'b0, 2);
    chk("pre_reset_addr_phase", {HSEL, HTRANS}, {1'b1, 2'b10});
    #2 HRESETn = 1'b0;
    #1;
    chk("midrst_bus", {HSEL, HTRANS, HWRITE, HSIZE, HADDR}, 0);
    chk("midrst_hwdata_rsp", {HWDATA, rsp_valid, cmd_ready}, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (4) @(negedge HCLK);
    chk("post_reset_ready", cmd_ready, 1);
    send(1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 2);
    drain(50);

`ifdef AHB_MASTER_TIMEOUT_EN
    // HREADY stuck low in the address phase: abort after 16 low cycles
    force_low = 1'b1;
    send(1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 16);
    drain(60);
    force_low = 1'b0;
    chk("timeout_bus_idle", {HSEL, HTRANS}, 0);
    send(1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 2);
    drain(50);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
